// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer (MUL/MULU/DIV/DIVU) beside the EX-stage ALU.
// Latency: start sampled at edge 0 -> done_o in cycle WIDTH+2 (early-out MUL: RUN length + 2).
// Backpressure: busy_o stalls the pipeline while working; start_i is ignored while busy_o=1.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   start_i, op_i        request and opcode (0=MUL 1=MULU 2=DIV 3=DIVU), accepted in IDLE/DONE
//   a_i, b_i             multiplicand/dividend, multiplier/divisor, captured with start_i
//   flush_i              abort the current op; also blocks a same-cycle start
//   busy_o               high in PREP/RUN/FIX
//   done_o               one-cycle pulse in DONE; hi_o/lo_o/dbz_o valid
//   hi_o, lo_o           product high/low word, or remainder/quotient
//   dbz_o                the divide just finished had a zero divisor
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let MUL/MULU leave RUN as soon
// as the remaining multiplier bits are all zero. Divides always take WIDTH cycles.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // raw operands as captured with start_i
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;  // operand signs differ
  logic               neg_a_q, neg_a_d;      // dividend was negative
  // shf: MUL = multiplicand shifted left each step; DIV = divisor in the low word.
  logic [2*WIDTH-1:0] shf_q, shf_d;
  // mplr: MUL = multiplier shifted right; DIV = dividend bits shifting out, quotient shifting in.
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  // acc: MUL = running product; DIV = partial remainder in the low WIDTH+1 bits.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  // Operand conditioning. Negating the most negative value yields the same bit
  // pattern, which read as unsigned is exactly its magnitude 2**(WIDTH-1).
  logic             is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;

  // Restoring divide step: bring down the next dividend bit and try to subtract.
  // One extra bit on the difference acts as the borrow out.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  assign rem_sh   = {acc_q[WIDTH-1:0], mplr_q[WIDTH-1]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, shf_q[WIDTH-1:0]};
  assign div_ge   = ~div_diff[WIDTH+1];

  logic last_cnt, mul_last;
  assign last_cnt = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
  // Stop once no set multiplier bits remain after this step.
  assign mul_last = last_cnt | (mplr_q[WIDTH-1:1] == '0);
`else
  assign mul_last = last_cnt;
`endif

  // Sign fix-up of the finished magnitudes.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   rem_mag, quot_fix, rem_fix;
  logic               div_zero;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign rem_mag  = acc_q[WIDTH-1:0];
  assign quot_fix = neg_res_q ? -mplr_q : mplr_q;
  assign rem_fix  = neg_a_q ? -rem_mag : rem_mag;
  assign div_zero = (shf_q[WIDTH-1:0] == '0);

  logic accept;
  assign accept = start_i & ~flush_i & ((state_q == S_IDLE) | (state_q == S_DONE));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    shf_d     = shf_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    if (accept) begin
      op_d = op_i;
      a_d  = a_i;
      b_d  = b_i;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_PREP;
      end

      S_PREP: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_RUN;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_a_d   = a_neg;
          acc_d     = '0;
          if (is_div) begin
            shf_d  = {{WIDTH{1'b0}}, b_mag};
            mplr_d = a_mag;
          end else begin
            shf_d  = {{WIDTH{1'b0}}, a_mag};
            mplr_d = b_mag;
          end
        end
      end

      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div) begin
            acc_d  = {{(WIDTH-1){1'b0}}, (div_ge ? div_diff[WIDTH:0] : rem_sh)};
            mplr_d = {mplr_q[WIDTH-2:0], div_ge};
            if (last_cnt) state_d = S_FIX;
          end else begin
            if (mplr_q[0]) acc_d = acc_q + shf_q;
            shf_d  = shf_q << 1;
            mplr_d = mplr_q >> 1;
            if (mul_last) state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (is_div) begin
            // Zero divisor: the restoring loop leaves the dividend magnitude as the
            // remainder, so re-signing it returns the dividend as given.
            lo_d  = div_zero ? {WIDTH{1'b1}} : quot_fix;
            hi_d  = rem_fix;
            dbz_d = div_zero;
          end else begin
            lo_d  = prod_fix[WIDTH-1:0];
            hi_d  = prod_fix[2*WIDTH-1:WIDTH];
            dbz_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = accept ? S_PREP : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      shf_q     <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      shf_q     <= shf_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o = (state_q == S_PREP) | (state_q == S_RUN) | (state_q == S_FIX);
  assign done_o = (state_q == S_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign dbz_o  = dbz_q;

endmodule
